// File: rtl/smpc_pad_scan.sv
// SMPC-side scan engine for one Saturn controller port.
// Walks TH/TR through the four digital-pad select phases, samples the returned
// data nibble at the end of each settle window and publishes the active-low pad
// word plus a presence flag once the whole scan has completed.
module smpc_pad_scan #(
   parameter int unsigned SETTLE = 8
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        CE,
   input  logic        START,
   input  logic [6:0]  PI,
   output logic [6:0]  PO,
   output logic        BUSY,
   output logic        DONE,
   output logic [15:0] JOY,
   output logic        PRESENT
);

   localparam logic [7:0] SettleCnt = 8'(SETTLE);
   localparam logic [6:0] PoIdle    = 7'h60;

   typedef enum logic [1:0] {StIdle, StSettle, StFinish} state_e;

   state_e      state_q;
   logic [1:0]  phase_q;
   logic [7:0]  count_q;
   logic [3:0]  nib_q [4];
   logic [6:0]  po_q;
   logic        busy_q;
   logic        done_q;
   logic [15:0] joy_q;
   logic        present_q;

   // Only the data nibble is meaningful on the port input.
   logic unused_pi;
   assign unused_pi = ^PI[6:4];

   // Phase index maps straight onto the select lines: TH = bit 0, TR = bit 1.
   function automatic logic [6:0] sel_po(logic [1:0] ph);
      return {ph[0], ph[1], 5'b00000};
   endfunction

   // Scan sequencer with registered port and status outputs.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= StIdle;
         phase_q   <= 2'd0;
         count_q   <= 8'd0;
         for (int i = 0; i < 4; i++) nib_q[i] <= 4'hF;
         po_q      <= PoIdle;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         joy_q     <= 16'hFFFF;
         present_q <= 1'b0;
      end else begin
         // DONE is a single CLK pulse even when CE stalls the engine.
         done_q <= 1'b0;
         if (CE) begin
            unique case (state_q)
               StIdle: begin
                  po_q <= PoIdle;
                  if (START) begin
                     po_q    <= sel_po(2'd0);
                     count_q <= SettleCnt;
                     phase_q <= 2'd0;
                     busy_q  <= 1'b1;
                     state_q <= StSettle;
                  end
               end
               StSettle: begin
                  if (count_q != 8'd0) begin
                     count_q <= count_q - 8'd1;
                  end else begin
                     nib_q[phase_q] <= PI[3:0];
                     if (phase_q != 2'd3) begin
                        phase_q <= phase_q + 2'd1;
                        po_q    <= sel_po(phase_q + 2'd1);
                        count_q <= SettleCnt;
                     end else begin
                        state_q <= StFinish;
                     end
                  end
               end
               StFinish: begin
                  // Word and presence flip together so readers never see a mix.
                  if (nib_q[3][2:0] == 3'b100) begin
                     joy_q     <= {nib_q[2], nib_q[1], nib_q[0], nib_q[3][3], 3'b111};
                     present_q <= 1'b1;
                  end else begin
                     joy_q     <= 16'hFFFF;
                     present_q <= 1'b0;
                  end
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  po_q    <= PoIdle;
                  state_q <= StIdle;
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   assign PO      = po_q;
   assign BUSY    = busy_q;
   assign DONE    = done_q;
   assign JOY     = joy_q;
   assign PRESENT = present_q;

endmodule

// File: tb/tb_smpc_pad_scan.sv
// Bench for smpc_pad_scan: two instances (SETTLE=8 and SETTLE=1) share stimulus,
// each answered by a pad model and tracked by a scan-level reference model.
module tb_smpc_pad_scan;

   localparam int S8 = 8;
   localparam int S1 = 1;

   logic        CLK = 1'b0;
   logic        RST, CE, START;
   logic [2:0]  junk = 3'b101;
   logic [15:0] padw;            // {phase3, phase2, phase1, phase0} nibbles
   logic [6:0]  pi8, pi1, po8, po1;
   logic        busy8, busy1, done8, done1, present8, present1;
   logic [15:0] joy8, joy1;

   int n_chk  = 0;
   int n_fail = 0;
   bit armed  = 0;

   always #5 CLK = ~CLK;

   // Pad answers with the nibble selected by the current TH/TR pair.
   assign pi8 = {junk, padw[4*int'({po8[5], po8[6]}) +: 4]};
   assign pi1 = {junk, padw[4*int'({po1[5], po1[6]}) +: 4]};

   smpc_pad_scan #(.SETTLE(S8)) u_dut8 (
      .CLK(CLK), .RST(RST), .CE(CE), .START(START), .PI(pi8), .PO(po8),
      .BUSY(busy8), .DONE(done8), .JOY(joy8), .PRESENT(present8)
   );

   smpc_pad_scan #(.SETTLE(S1)) u_dut1 (
      .CLK(CLK), .RST(RST), .CE(CE), .START(START), .PI(pi1), .PO(po1),
      .BUSY(busy1), .DONE(done1), .JOY(joy1), .PRESENT(present1)
   );

   // Scan model: e counts CE cycles since the accepting cycle.
   typedef struct packed {
      logic        busy;
      int          e;
      logic [15:0] nib;
      logic [15:0] joy;
      logic        present;
      logic        done;
   } model_t;

   model_t m8 = '0;
   model_t m1 = '0;

   function automatic model_t step(model_t m, int s, logic rst, logic ce, logic start,
                                   logic [15:0] pw);
      model_t n = m;
      int p;
      n.done = 1'b0;
      if (rst) begin
         n.busy = 1'b0; n.e = 0; n.nib = 16'hFFFF; n.joy = 16'hFFFF; n.present = 1'b0;
      end else if (ce) begin
         if (!m.busy) begin
            if (start) begin
               n.busy = 1'b1;
               n.e    = 0;
            end
         end else begin
            n.e = m.e + 1;
            if ((n.e % (s + 1)) == 0 && n.e <= 4 * (s + 1)) begin
               p = n.e / (s + 1) - 1;
               n.nib[4*p +: 4] = pw[4*p +: 4];
            end
            if (n.e == 4 * (s + 1) + 1) begin
               if (n.nib[14:12] == 3'b100) begin
                  n.joy     = {n.nib[11:8], n.nib[7:4], n.nib[3:0], n.nib[15], 3'b111};
                  n.present = 1'b1;
               end else begin
                  n.joy     = 16'hFFFF;
                  n.present = 1'b0;
               end
               n.done = 1'b1;
               n.busy = 1'b0;
            end
         end
      end
      return n;
   endfunction

   function automatic logic [6:0] exp_po(model_t m, int s);
      int p;
      logic [1:0] pp;
      if (!m.busy) return 7'h60;
      p = m.e / (s + 1);
      if (p > 3) p = 3;
      pp = p[1:0];
      return {pp[0], pp[1], 5'b00000};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance the models on every edge and compare both DUTs just after it.
   always @(posedge CLK) begin
      if (RST) armed = 1;
      m8 = step(m8, S8, RST, CE, START, padw);
      m1 = step(m1, S1, RST, CE, START, padw);
      #1;
      if (armed) begin
         chk("po8", {25'd0, po8}, {25'd0, exp_po(m8, S8)});
         chk("busy8", {31'd0, busy8}, {31'd0, m8.busy});
         chk("done8", {31'd0, done8}, {31'd0, m8.done});
         chk("joy8", {16'd0, joy8}, {16'd0, m8.joy});
         chk("present8", {31'd0, present8}, {31'd0, m8.present});
         chk("po1", {25'd0, po1}, {25'd0, exp_po(m1, S1)});
         chk("busy1", {31'd0, busy1}, {31'd0, m1.busy});
         chk("done1", {31'd0, done1}, {31'd0, m1.done});
         chk("joy1", {16'd0, joy1}, {16'd0, m1.joy});
         chk("present1", {31'd0, present1}, {31'd0, m1.present});
      end
   end

   // Leaves us at the negedge just after the accepting edge.
   task automatic pulse_start();
      @(negedge CLK) START = 1'b1;
      @(negedge CLK) START = 1'b0;
   endtask

   task automatic wait_idle();
      int t = 0;
      while ((busy8 || busy1) && t < 500) begin
         @(negedge CLK);
         t++;
      end
      chk("idle_timeout", {31'd0, busy8 | busy1}, 32'd0);
   endtask

   initial begin
      int ndone, kdone, ce_cnt;
      bit seen;
      RST = 1'b1; CE = 1'b1; START = 1'b0; padw = 16'h4E7F;
      repeat (3) @(negedge CLK);
      RST = 1'b0;
      chk("rst_po", {25'd0, po8}, 32'h60);
      chk("rst_joy", {16'd0, joy8}, 32'hFFFF);
      chk("rst_present", {31'd0, present8}, 32'd0);
      chk("rst_busy", {31'd0, busy8}, 32'd0);
      chk("rst_done", {31'd0, done8}, 32'd0);

      // Pad with Start, Up and L pressed, ID=100.
      pulse_start();
      ndone = 0; kdone = -1;
      for (int k = 0; k < 45; k++) begin
         if (k == 0 || k == 8)  chk("sel0", {25'd0, po8}, 32'h00);
         if (k == 9 || k == 17) chk("sel1", {25'd0, po8}, 32'h40);
         if (k == 18 || k == 26) chk("sel2", {25'd0, po8}, 32'h20);
         if (k == 27 || k == 36) chk("sel3", {25'd0, po8}, 32'h60);
         if (done8) begin ndone++; kdone = k; end
         @(negedge CLK);
      end
      chk("done_latency", kdone, 37);
      chk("done_count", ndone, 1);
      chk("joy_pad", {16'd0, joy8}, 32'hE7F7);
      chk("present_pad", {31'd0, present8}, 32'd1);
      wait_idle();

      // No pad: ID=111.
      padw = 16'hFE7F;
      pulse_start();
      ndone = 0;
      for (int k = 0; k < 45; k++) begin
         if (done8) ndone++;
         @(negedge CLK);
      end
      chk("nopad_done", ndone, 1);
      chk("nopad_joy", {16'd0, joy8}, 32'hFFFF);
      chk("nopad_present", {31'd0, present8}, 32'd0);
      wait_idle();

      // START during phase1 is ignored.
      padw = 16'h4E7F;
      pulse_start();
      repeat (11) @(negedge CLK);
      chk("busy_mid", {31'd0, busy8}, 32'd1);
      START = 1'b1;
      @(negedge CLK) START = 1'b0;
      ndone = 0;
      for (int k = 0; k < 60; k++) begin
         if (done8) ndone++;
         @(negedge CLK);
      end
      chk("mid_start_one_done", ndone, 1);
      wait_idle();
      pulse_start();
      ndone = 0;
      for (int k = 0; k < 50; k++) begin
         if (done8) ndone++;
         @(negedge CLK);
      end
      chk("second_scan_done", ndone, 1);
      wait_idle();

      // Reset during phase2 aborts without DONE.
      pulse_start();
      repeat (20) @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK) RST = 1'b0;
      chk("abort_po", {25'd0, po8}, 32'h60);
      chk("abort_busy", {31'd0, busy8}, 32'd0);
      chk("abort_joy", {16'd0, joy8}, 32'hFFFF);
      ndone = 0;
      for (int k = 0; k < 50; k++) begin
         if (done8) ndone++;
         @(negedge CLK);
      end
      chk("abort_no_done", ndone, 0);
      wait_idle();

      // CE active one cycle in three, SETTLE=1 instance.
      ce_cnt = 0; seen = 0;
      @(negedge CLK) begin CE = 1'b1; START = 1'b1; end
      for (int c = 1; c < 60 && !seen; c++) begin
         @(negedge CLK);
         if (done1) begin
            seen = 1;
            chk("ce_latency", ce_cnt, 9);
         end
         START = 1'b0;
         CE = (c % 3 == 0);
         if (CE) ce_cnt++;
      end
      chk("ce_done_seen", {31'd0, seen}, 32'd1);
      chk("ce_joy", {16'd0, joy1}, 32'hE7F7);
      chk("ce_present", {31'd0, present1}, 32'd1);
      @(negedge CLK) CE = 1'b1;
      wait_idle();

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         @(negedge CLK);
         junk = 3'($urandom);
         if (!m8.busy && !m1.busy && $urandom_range(0, 3) == 0) begin
            padw = 16'($urandom);
            if ($urandom_range(0, 1) == 1) padw[14:12] = 3'b100;
         end
         CE    = ($urandom_range(0, 3) != 0);
         START = ($urandom_range(0, 9) == 0);
         RST   = ($urandom_range(0, 499) == 0);
      end
      @(negedge CLK) begin RST = 1'b0; START = 1'b0; CE = 1'b1; end
      wait_idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
